// File: rtl/tcam_pkg.sv
// Shared types and TCAM pin widths for the TCAM request sequencer.
package tcam_pkg;

    localparam int TCAM_ADDR_W = 28;
    localparam int TCAM_DATA_W = 32;
    localparam int TCAM_MASK_W = 4;
    localparam int TCAM_PMA_W  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OP_WRITE  = 1'b0,
        OP_SEARCH = 1'b1
    } op_e;

endpackage

// File: rtl/tcam_req_ctrl.sv
// Single-outstanding command sequencer driving the TCAM pins for one cycle,
// then capturing the PMA after a fixed access latency.
module tcam_req_ctrl
    import tcam_pkg::*;
#(
    parameter int ACC_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                   in_clk,
    input  logic                   in_rst_n,
    input  logic                   in_cmd_valid,
    output logic                   out_cmd_ready,
    input  logic                   in_cmd_op,
    input  logic [TCAM_ADDR_W-1:0] in_cmd_addr,
    input  logic [TCAM_DATA_W-1:0] in_cmd_wdata,
    input  logic [TCAM_MASK_W-1:0] in_cmd_wmask,
    output logic                   out_resp_valid,
    input  logic                   in_resp_ready,
    output logic                   out_resp_op,
    output logic [TCAM_PMA_W-1:0]  out_resp_pma,
    output logic                   out_tcam_csb,
    output logic                   out_tcam_web,
    output logic [TCAM_MASK_W-1:0] out_tcam_wmask,
    output logic [TCAM_ADDR_W-1:0] out_tcam_addr,
    output logic [TCAM_DATA_W-1:0] out_tcam_wdata,
    input  logic [TCAM_PMA_W-1:0]  in_tcam_pma,
    output logic [CNT_W-1:0]       out_search_cnt,
    output logic [CNT_W-1:0]       out_write_cnt
);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [TCAM_ADDR_W-1:0] addr_q, addr_d;
    logic [TCAM_DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]             wait_q, wait_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    op_e                    resp_op_q, resp_op_d;
    logic [TCAM_PMA_W-1:0]  resp_pma_q, resp_pma_d;
    logic                   csb_q, csb_d;
    logic                   web_q, web_d;
    logic [TCAM_MASK_W-1:0] tcam_wmask_q, tcam_wmask_d;
    logic [CNT_W-1:0]       search_cnt_q, search_cnt_d;
    logic [CNT_W-1:0]       write_cnt_q, write_cnt_d;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_d       = wait_q;
        cmd_ready_d  = cmd_ready_q;
        resp_valid_d = resp_valid_q;
        resp_op_d    = resp_op_q;
        resp_pma_d   = resp_pma_q;
        search_cnt_d = search_cnt_q;
        write_cnt_d  = write_cnt_q;
        csb_d        = 1'b1;
        web_d        = 1'b1;
        tcam_wmask_d = '0;

        case (state_q)
            IDLE: begin
                // Pin values for the ISSUE cycle are computed here so they
                // leave the block straight from flops.
                if (in_cmd_valid) begin
                    op_d         = op_e'(in_cmd_op);
                    addr_d       = in_cmd_addr;
                    wdata_d      = in_cmd_wdata;
                    csb_d        = 1'b0;
                    web_d        = ~in_cmd_op;
                    tcam_wmask_d = in_cmd_op ? '0 : in_cmd_wmask;
                    cmd_ready_d  = 1'b0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = 4'(ACC_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == 4'd0) begin
                    resp_op_d    = op_q;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                    if (op_q == OP_SEARCH) begin
                        resp_pma_d   = in_tcam_pma;
                        search_cnt_d = (search_cnt_q == '1) ? search_cnt_q : search_cnt_q + 1'b1;
                    end else begin
                        resp_pma_d  = '0;
                        write_cnt_d = (write_cnt_q == '1) ? write_cnt_q : write_cnt_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RESP: begin
                if (in_resp_ready) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_WRITE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_q       <= '0;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_op_q    <= OP_WRITE;
            resp_pma_q   <= '0;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            tcam_wmask_q <= '0;
            search_cnt_q <= '0;
            write_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_q       <= wait_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_op_q    <= resp_op_d;
            resp_pma_q   <= resp_pma_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            tcam_wmask_q <= tcam_wmask_d;
            search_cnt_q <= search_cnt_d;
            write_cnt_q  <= write_cnt_d;
        end
    end

    assign out_cmd_ready  = cmd_ready_q;
    assign out_resp_valid = resp_valid_q;
    assign out_resp_op    = resp_op_q;
    assign out_resp_pma   = resp_pma_q;
    assign out_tcam_csb   = csb_q;
    assign out_tcam_web   = web_q;
    assign out_tcam_wmask = tcam_wmask_q;
    assign out_tcam_addr  = addr_q;
    assign out_tcam_wdata = wdata_q;
    assign out_search_cnt = search_cnt_q;
    assign out_write_cnt  = write_cnt_q;

endmodule
